// File: rtl/lock_ctrl_param.sv
// Keypad door-lock controller: password set/confirm, challenge with error counting,
// lockout penalty, keypad shuffle and automatic relock.
`timescale 1ns/1ps
module lock_ctrl_param #(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned ERR_W          = 4,
    parameter int unsigned MAX_ERR        = 10,
    parameter int unsigned LONG_PRESS_CYC = 80,
    parameter int unsigned SHUFFLE_CYC    = 9,
    parameter int unsigned LOCKOUT_CYC    = 200,
    parameter int unsigned RELOCK_CYC     = 500
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             confirm_i,
    input  logic             shuffle_i,
    input  logic             same_i,
    input  logic             master_same_i,
    input  logic             input_valid_i,
    input  logic             buff_limit_i,
    input  logic             mem_limit_i,
    output logic             mem_rst_o,
    output logic             mem_sl_o,
    output logic             buff_rst_o,
    output logic             buff_sl_o,
    output logic             shuffle_init_o,
    output logic             locked_o,
    output logic             lockout_o,
    output logic [ERR_W-1:0] error_cnt_o
);

    typedef enum logic [2:0] {
        StInit,
        StSetPsw,
        StConfirm,
        StLocked,
        StChallenge,
        StShuffle,
        StUnlocked,
        StPenalty
    } state_e;

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ShufLast   = CNT_W'(SHUFFLE_CYC - 1);
    localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RelockLast = CNT_W'(RELOCK_CYC - 1);
    localparam logic [CNT_W-1:0] LongPress  = CNT_W'(LONG_PRESS_CYC);
    localparam logic [ERR_W-1:0] ErrMax     = ERR_W'(MAX_ERR);
    localparam logic [ERR_W-1:0] ErrLast    = ERR_W'(MAX_ERR - 1);
    localparam logic [ERR_W-1:0] ErrOne     = ERR_W'(1);

    state_e           state_q, ret_q;
    logic             conf_q, shuf_q;
    logic [CNT_W-1:0] cnt_q, hold_q, idle_q;
    logic [ERR_W-1:0] err_q;
    logic             mem_rst_q, mem_sl_q, buff_rst_q, buff_sl_q, shuffle_init_q;

    logic             conf_rel, shuf_rel, chal_ok;
    logic [CNT_W-1:0] cnt_inc, hold_inc, idle_inc;
    logic [ERR_W-1:0] err_inc;

    assign conf_rel = conf_q & ~confirm_i;
    assign shuf_rel = shuf_q & ~shuffle_i;
    assign chal_ok  = master_same_i | (same_i & (err_q < ErrMax));
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    assign hold_inc = (hold_q == CntMax) ? hold_q : hold_q + CntOne;
    assign idle_inc = (idle_q == CntMax) ? idle_q : idle_q + CntOne;
    assign err_inc  = (err_q >= ErrMax) ? ErrMax : err_q + ErrOne;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= StInit;
            ret_q          <= StInit;
            conf_q         <= 1'b0;
            shuf_q         <= 1'b0;
            cnt_q          <= '0;
            hold_q         <= '0;
            idle_q         <= '0;
            err_q          <= '0;
            mem_rst_q      <= 1'b0;
            mem_sl_q       <= 1'b0;
            buff_rst_q     <= 1'b0;
            buff_sl_q      <= 1'b0;
            shuffle_init_q <= 1'b0;
        end else begin
            conf_q         <= confirm_i;
            shuf_q         <= shuffle_i;
            mem_rst_q      <= 1'b0;
            mem_sl_q       <= 1'b0;
            buff_rst_q     <= 1'b0;
            buff_sl_q      <= 1'b0;
            shuffle_init_q <= 1'b0;
            cnt_q          <= cnt_inc;
            hold_q         <= confirm_i ? hold_inc : hold_q;
            idle_q         <= confirm_i ? '0 : idle_inc;

            // Each transition clears the counters; later assignments override the defaults.
            unique case (state_q)
                StInit: begin
                    state_q   <= StSetPsw;
                    mem_rst_q <= 1'b1;
                    {cnt_q, hold_q, idle_q} <= '0;
                end
                StSetPsw: begin
                    if (shuf_rel) begin
                        ret_q          <= StSetPsw;
                        state_q        <= StShuffle;
                        shuffle_init_q <= 1'b1;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (conf_rel) begin
                        state_q    <= StConfirm;
                        buff_rst_q <= 1'b1;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (input_valid_i) begin
                        mem_rst_q <= mem_limit_i;
                        mem_sl_q  <= ~mem_limit_i;
                    end
                end
                StConfirm: begin
                    if (shuf_rel) begin
                        ret_q          <= StConfirm;
                        state_q        <= StShuffle;
                        shuffle_init_q <= 1'b1;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (conf_rel) begin
                        state_q   <= same_i ? StLocked : StSetPsw;
                        mem_rst_q <= ~same_i;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (input_valid_i) begin
                        if (buff_limit_i) begin
                            state_q   <= StSetPsw;
                            mem_rst_q <= 1'b1;
                            {cnt_q, hold_q, idle_q} <= '0;
                        end else begin
                            buff_sl_q <= 1'b1;
                        end
                    end
                end
                StLocked: begin
                    if (conf_rel) begin
                        state_q    <= StChallenge;
                        buff_rst_q <= 1'b1;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end
                end
                StChallenge: begin
                    if (shuf_rel) begin
                        ret_q          <= StChallenge;
                        state_q        <= StShuffle;
                        shuffle_init_q <= 1'b1;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (conf_rel && chal_ok) begin
                        state_q <= StUnlocked;
                        err_q   <= '0;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (conf_rel || (input_valid_i && buff_limit_i)) begin
                        err_q   <= err_inc;
                        state_q <= (err_inc == ErrMax) ? StPenalty : StLocked;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (input_valid_i) begin
                        buff_sl_q <= 1'b1;
                    end
                end
                StShuffle: begin
                    if (cnt_q >= ShufLast) begin
                        state_q <= ret_q;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end
                end
                StUnlocked: begin
                    if (conf_rel) begin
                        state_q   <= (hold_q < LongPress) ? StLocked : StSetPsw;
                        mem_rst_q <= (hold_q >= LongPress);
                        {cnt_q, hold_q, idle_q} <= '0;
                    end else if (!confirm_i && idle_q >= RelockLast) begin
                        state_q <= StLocked;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end
                end
                StPenalty: begin
                    if (cnt_q >= LockLast) begin
                        state_q <= StLocked;
                        err_q   <= ErrLast;
                        {cnt_q, hold_q, idle_q} <= '0;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign mem_rst_o      = mem_rst_q;
    assign mem_sl_o       = mem_sl_q;
    assign buff_rst_o     = buff_rst_q;
    assign buff_sl_o      = buff_sl_q;
    assign shuffle_init_o = shuffle_init_q;
    assign error_cnt_o    = err_q;
    assign locked_o       = (state_q == StLocked) || (state_q == StChallenge) ||
                            (state_q == StPenalty);
    assign lockout_o      = (state_q == StPenalty);

endmodule
